parity_replay_ctrl: RTL and testbench
=====================================

Name: parity_replay_ctrl

Overview:
Pipeline controller for one data-plus-parity stage register. It gates the stage load enable and checks the stage's registered data/parity pair for soft errors. On an error it flushes the stage and requests a replay from upstream, retrying up to a limit before declaring a fatal fault. It sits beside the stage register, between upstream issue logic and the downstream stage.

Parameters:
DATA_SIZE, 32, width of the stage data field (parity excluded)
MAX_RETRY, 3, consecutive failed replays tolerated before FATAL (1..15)
CNT_W, 16, width of the saturating error counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  upstream word present at stage input
in_ready  out  1  controller accepts the upstream word this cycle
stage_en  out  1  load enable to stage register; equals in_valid & in_ready
stage_flush  out  1  one-cycle clear to stage register (drives its reset alongside global reset)
stage_data  in  DATA_SIZE  registered data from stage
stage_parity  in  1  registered parity bit from stage
out_valid  out  1  stage holds a parity-clean word for downstream
out_ready  in  1  downstream accepts the word
retry_req  out  1  one-cycle pulse: upstream must re-issue the last word
parity_err  out  1  combinational: stage valid and parity mismatch
err_count  out  CNT_W  total parity errors since reset, saturating
fatal  out  1  sticky fault flag
state  out  2  FSM state: RUN=0, FLUSH=1, REPLAY=2, FATAL=3

Behaviour:
- Reset: state=RUN, internal stage_valid=0, retry_cnt=0, err_count=0, fatal=0. All outputs are low or zero while reset is high and in the first cycle after it.
- Parity rule: even parity. mismatch = (^stage_data) ^ stage_parity. parity_err = stage_valid & mismatch & (state==RUN).
- stage_valid: set on stage_en; cleared on an out_valid&out_ready handshake without a same-cycle stage_en, on stage_flush, and on reset.
- RUN:
  - out_valid = stage_valid & ~mismatch.
  - in_ready = ~stage_valid | (out_ready & ~mismatch).
  - This allows back-to-back words at full rate with zero bubbles. Stage-to-output latency is 1 cycle after stage_en.
  - On parity_err: err_count += 1 (saturating at all-ones); retry_cnt += 1.
    - If the new retry_cnt equals MAX_RETRY, next state is FATAL.
    - Otherwise next state is FLUSH.
    - in_ready=0 and out_valid=0 in the error cycle.
  - On an out handshake of a clean word, retry_cnt clears to 0.
- FLUSH: exactly 1 cycle. stage_flush=1, in_ready=0, out_valid=0, stage_valid is cleared. Next state is REPLAY.
- REPLAY:
  - retry_req=1 on the first REPLAY cycle only; out_valid=0.
  - in_ready=1. The first in_valid is accepted (stage_en=1) and the next state is RUN.
  - The FSM waits indefinitely for in_valid.
- FATAL:
  - fatal=1; in_ready, out_valid, stage_en, retry_req and stage_flush are all 0.
  - stage_flush is asserted once on entry to FATAL (same cycle as the transition).
  - Only reset exits FATAL. err_count is frozen.
- Simultaneous events:
  - parity_err overrides out_ready; a bad word is never emitted.
  - reset overrides every state, including mid-FLUSH, mid-REPLAY and FATAL.
- retry_cnt counts only consecutive failures of the same replayed word. A good delivered word resets it.

Test Plan:
- Reset: assert reset 2 cycles mid-stream -> all outputs 0, state=0, err_count=0 on the first post-reset cycle.
- Clean stream: 8 words with correct even parity (e.g. data=0x00000003, parity=0), out_ready always 1 -> 8 out_valid handshakes on consecutive cycles, in_ready constantly 1, err_count=0.
- Backpressure: out_ready=0 for 3 cycles while a word is held -> in_ready=0 and out_valid=1 held stable, no stage_en. Release -> word delivered, next word loads the same cycle.
- Single error: data=0x00000001, parity=0 -> parity_err=1, next cycle stage_flush=1 (state=1), then retry_req pulse (state=2). Upstream replays with parity=1 -> accepted, out_valid next cycle, err_count=1, nothing emitted for the bad word.
- Fatal: MAX_RETRY=3, same corrupted word replayed 3 times -> 3 errors, 2 FLUSH/REPLAY cycles, third error goes to FATAL. fatal=1, err_count=3, in_ready stays 0 for 20 cycles, reset clears everything.
- Saturation: CNT_W=2, MAX_RETRY=15, 5 isolated errors each followed by a good replay -> err_count stops at 3, no wrap to 0.

Source files
------------

// File: rtl/parity_replay_ctrl.sv
// parity_replay_ctrl: load-enable gating and soft-error recovery for one
// data+parity stage register. A parity failure flushes the stage and asks
// upstream to replay the word. Too many consecutive failures latch FATAL.
module parity_replay_ctrl #(
  parameter int DATA_SIZE = 32,
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 stage_en,
  output logic                 stage_flush,
  input  logic [DATA_SIZE-1:0] stage_data,
  input  logic                 stage_parity,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 retry_req,
  output logic                 parity_err,
  output logic [CNT_W-1:0]     err_count,
  output logic                 fatal,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    REPLAY = 2'd2,
    FATAL  = 2'd3
  } state_e;

  localparam logic [3:0]       RETRY_LIM = 4'(MAX_RETRY);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             stage_valid_q, stage_valid_d;
  logic [3:0]       retry_cnt_q, retry_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             replay_first_q;
  logic             hold_q;

  // Raw (ungated) FSM outputs.
  logic in_rdy_raw, out_vld_raw, flush_raw, rreq_raw, perr_raw;
  logic mismatch;
  logic live;

  // Even parity over data plus parity bit must be zero.
  assign mismatch = (^stage_data) ^ stage_parity;

  // Outputs stay quiet while reset is high and for one cycle after it.
  assign live = ~(reset | hold_q);

  assign in_ready    = live & in_rdy_raw;
  assign stage_en    = in_ready & in_valid;
  assign stage_flush = live & flush_raw;
  assign out_valid   = live & out_vld_raw;
  assign retry_req   = live & rreq_raw;
  assign parity_err  = live & perr_raw;
  assign err_count   = live ? err_cnt_q : '0;
  assign fatal       = live & (state_q == FATAL);
  assign state       = live ? state_q : RUN;

  // Next-state and raw output decode.
  always_comb begin
    state_d     = state_q;
    retry_cnt_d = retry_cnt_q;
    err_cnt_d   = err_cnt_q;
    in_rdy_raw  = 1'b0;
    out_vld_raw = 1'b0;
    flush_raw   = 1'b0;
    rreq_raw    = 1'b0;
    perr_raw    = 1'b0;
    case (state_q)
      RUN: begin
        perr_raw = stage_valid_q & mismatch;
        if (perr_raw) begin
          // A bad word is never emitted, regardless of out_ready.
          err_cnt_d   = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_ONE;
          retry_cnt_d = retry_cnt_q + 4'd1;
          if (retry_cnt_d == RETRY_LIM) begin
            state_d   = FATAL;
            flush_raw = 1'b1;
          end else begin
            state_d = FLUSH;
          end
        end else begin
          out_vld_raw = stage_valid_q;
          in_rdy_raw  = ~stage_valid_q | out_ready;
          if (stage_valid_q && out_ready) retry_cnt_d = 4'd0;
        end
      end
      FLUSH: begin
        flush_raw = 1'b1;
        state_d   = REPLAY;
      end
      REPLAY: begin
        rreq_raw   = replay_first_q;
        in_rdy_raw = 1'b1;
        if (in_valid) state_d = RUN;
      end
      default: ;  // FATAL: everything idle until reset
    endcase
  end

  // Stage occupancy: flush wins, then a new load, then a drain.
  always_comb begin
    stage_valid_d = stage_valid_q;
    if (stage_flush)                stage_valid_d = 1'b0;
    else if (stage_en)              stage_valid_d = 1'b1;
    else if (out_valid & out_ready) stage_valid_d = 1'b0;
  end

  // State, counters and the stage-valid flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      stage_valid_q  <= 1'b0;
      retry_cnt_q    <= 4'd0;
      err_cnt_q      <= '0;
      replay_first_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      stage_valid_q  <= stage_valid_d;
      retry_cnt_q    <= retry_cnt_d;
      err_cnt_q      <= err_cnt_d;
      replay_first_q <= (state_q == FLUSH);
    end
  end

  // One-cycle delayed copy of reset for the post-reset quiet cycle.
  always_ff @(posedge clk) begin
    hold_q <= reset;
  end

endmodule

// File: tb/tb_parity_replay_ctrl.sv
// Bench for parity_replay_ctrl: directed stimulus with a queue scoreboard.
// Instance A uses default parameters; instance B (CNT_W=2, MAX_RETRY=15)
// exercises error-counter saturation.
module tb_parity_replay_ctrl;

  logic clk;
  logic reset;

  // Instance A
  logic        a_in_valid, a_in_ready, a_stage_en, a_stage_flush;
  logic [31:0] a_stage_data, a_up_data;
  logic        a_stage_par, a_up_par;
  logic        a_out_valid, a_out_ready, a_retry_req, a_parity_err, a_fatal;
  logic [15:0] a_err_count;
  logic [1:0]  a_state;

  // Instance B
  logic        b_in_valid, b_in_ready, b_stage_en, b_stage_flush;
  logic [7:0]  b_stage_data, b_up_data;
  logic        b_stage_par, b_up_par;
  logic        b_out_valid, b_out_ready, b_retry_req, b_parity_err, b_fatal;
  logic [1:0]  b_err_count;
  logic [1:0]  b_state;

  int checks   = 0;
  int failures = 0;

  logic [32:0] qa[$];
  logic [8:0]  qb[$];

  parity_replay_ctrl #(.DATA_SIZE(32), .MAX_RETRY(3), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .stage_en(a_stage_en), .stage_flush(a_stage_flush),
    .stage_data(a_stage_data), .stage_parity(a_stage_par),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .retry_req(a_retry_req),
    .parity_err(a_parity_err), .err_count(a_err_count), .fatal(a_fatal),
    .state(a_state));

  parity_replay_ctrl #(.DATA_SIZE(8), .MAX_RETRY(15), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .stage_en(b_stage_en), .stage_flush(b_stage_flush),
    .stage_data(b_stage_data), .stage_parity(b_stage_par),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .retry_req(b_retry_req),
    .parity_err(b_parity_err), .err_count(b_err_count), .fatal(b_fatal),
    .state(b_state));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stage registers controlled by the DUTs.
  always @(posedge clk) begin
    if (reset || a_stage_flush) {a_stage_par, a_stage_data} <= '0;
    else if (a_stage_en)        {a_stage_par, a_stage_data} <= {a_up_par, a_up_data};
    if (reset || b_stage_flush) {b_stage_par, b_stage_data} <= '0;
    else if (b_stage_en)        {b_stage_par, b_stage_data} <= {b_up_par, b_up_data};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Monitors: every delivered word must be the next expected clean word.
  initial forever begin
    @(negedge clk);
    if (a_out_valid && a_out_ready) begin
      checks++;
      if (qa.size() == 0) begin
        failures++;
        $display("FAIL a_out_word: got %0h unexpected (none queued)", {a_stage_par, a_stage_data});
      end else begin
        if ({a_stage_par, a_stage_data} !== qa[0]) begin
          failures++;
          $display("FAIL a_out_word: got %0h expected %0h", {a_stage_par, a_stage_data}, qa[0]);
        end
        void'(qa.pop_front());
      end
    end
    if (b_out_valid && b_out_ready) begin
      checks++;
      if (qb.size() == 0) begin
        failures++;
        $display("FAIL b_out_word: got %0h unexpected (none queued)", {b_stage_par, b_stage_data});
      end else begin
        if ({b_stage_par, b_stage_data} !== qb[0]) begin
          failures++;
          $display("FAIL b_out_word: got %0h expected %0h", {b_stage_par, b_stage_data}, qb[0]);
        end
        void'(qb.pop_front());
      end
    end
  end

  // Present a word on A and hold it until accepted; returns stall count.
  task automatic send_a(input logic [31:0] d, input logic p, output int waits);
    logic acc;
    a_in_valid = 1'b1;
    a_up_data  = d;
    a_up_par   = p;
    waits      = 0;
    forever begin
      @(negedge clk);
      acc = a_in_ready;
      tick();
      if (acc) break;
      waits++;
      if (waits > 50) begin
        checks++;
        failures++;
        $display("FAIL send_a_timeout: got no in_ready expected accept within 50 cycles");
        a_in_valid = 1'b0;
        break;
      end
    end
  endtask

  // One parity error on A followed by a clean replay.
  task automatic single_err(input logic [15:0] exp_cnt);
    int w;
    send_a(32'h0000_0001, 1'b0, w);
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("err_cycle {perr,ov,ir,state}", {a_parity_err, a_out_valid, a_in_ready, a_state}, 5'b10000);
    tick();
    @(negedge clk);
    chk("flush_cycle {flush,state,ir,ov}", {a_stage_flush, a_state, a_in_ready, a_out_valid}, 5'b10100);
    chk("flush_err_count", a_err_count, exp_cnt);
    tick();
    @(negedge clk);
    chk("replay_first {rreq,state,ir,flush}", {a_retry_req, a_state, a_in_ready, a_stage_flush}, 5'b11010);
    tick();
    @(negedge clk);
    chk("replay_wait {rreq,state}", {a_retry_req, a_state}, 3'b010);
    tick();
    qa.push_back({1'b1, 32'h0000_0001});
    send_a(32'h0000_0001, 1'b1, w);
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("replay_out {ov,state}", {a_out_valid, a_state}, 3'b100);
    tick(); tick();
    chk("single_err_count", a_err_count, exp_cnt);
    chk("single_err_drained", qa.size(), 0);
  endtask

  function automatic logic [31:0] a_outs();
    return {a_in_ready, a_stage_en, a_stage_flush, a_out_valid, a_retry_req,
            a_parity_err, a_fatal, a_state, a_err_count};
  endfunction

  logic [31:0] clean_d [8] = '{32'h0000_0003, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000,
                               32'h1234_5678, 32'h0000_000F, 32'hA5A5_A5A5, 32'h0000_0007};
  logic        clean_p [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int w;
    reset = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_up_data = '0; a_up_par = 1'b0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_up_data = '0; b_up_par = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_reset_a_outputs", a_outs(), 0);
    chk("post_reset_b_outputs", {b_in_ready, b_out_valid, b_fatal, b_state, b_err_count}, 0);
    tick();
    @(negedge clk);
    chk("run_idle_in_ready", a_in_ready, 1);
    tick();

    // Clean stream at full rate.
    for (int i = 0; i < 8; i++) begin
      qa.push_back({clean_p[i], clean_d[i]});
      send_a(clean_d[i], clean_p[i], w);
      chk("clean_no_stall", w, 0);
    end
    a_in_valid = 1'b0;
    repeat (3) tick();
    chk("clean_drained", qa.size(), 0);
    chk("clean_err_count", a_err_count, 0);

    // Backpressure.
    a_out_ready = 1'b0;
    qa.push_back({1'b0, 32'h0000_0003});
    send_a(32'h0000_0003, 1'b0, w);
    qa.push_back({1'b0, 32'h0000_000F});
    a_in_valid = 1'b1; a_up_data = 32'h0000_000F; a_up_par = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold {ir,ov,en}", {a_in_ready, a_out_valid, a_stage_en}, 3'b010);
      tick();
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release {ir,ov,en}", {a_in_ready, a_out_valid, a_stage_en}, 3'b111);
    tick();
    a_in_valid = 1'b0;
    repeat (3) tick();
    chk("bp_drained", qa.size(), 0);

    single_err(16'd1);

    // Reset mid-stream with a word held under backpressure.
    a_out_ready = 1'b0;
    send_a(32'h0000_0003, 1'b0, w);
    a_in_valid = 1'b1; a_up_data = 32'h0000_000F; a_up_par = 1'b0;
    @(negedge clk);
    chk("pre_reset_held", a_out_valid, 1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("in_reset_outputs_1", a_outs(), 0);
    tick();
    @(negedge clk);
    chk("in_reset_outputs_2", a_outs(), 0);
    tick();
    reset = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    @(negedge clk);
    chk("mid_reset_first_cycle", a_outs(), 0);
    tick();
    @(negedge clk);
    chk("mid_reset_run {state,ov,ir,err}", {a_state, a_out_valid, a_in_ready, a_err_count}, {2'd0, 1'b0, 1'b1, 16'd0});
    tick();

    // Good replay must clear retry count before the fatal sequence.
    single_err(16'd1);

    // Fatal: three consecutive failures of the same word.
    for (int k = 1; k <= 3; k++) begin
      send_a(32'h0000_0001, 1'b0, w);
      a_in_valid = 1'b0;
      @(negedge clk);
      chk("fatal_seq_perr", a_parity_err, 1);
      chk("fatal_seq_entry_flush", a_stage_flush, (k == 3) ? 1 : 0);
      tick();
      if (k < 3) begin
        @(negedge clk);
        chk("fatal_seq_flush_state", a_state, 1);
        tick();
        @(negedge clk);
        chk("fatal_seq_replay {rreq,state}", {a_retry_req, a_state}, 3'b110);
        tick();
      end
    end
    @(negedge clk);
    chk("fatal_state {fatal,state,ir,ov,flush,rreq}",
        {a_fatal, a_state, a_in_ready, a_out_valid, a_stage_flush, a_retry_req}, 7'b1110000);
    chk("fatal_err_count", a_err_count, 16'd4);
    tick();
    a_in_valid = 1'b1; a_up_data = 32'h0000_0003; a_up_par = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("fatal_hold", a_outs(), {6'b000000, 1'b1, 2'd3, 16'd4} << 0);
      tick();
    end
    reset = 1'b1; a_in_valid = 1'b0;
    @(negedge clk);
    chk("fatal_in_reset", a_outs(), 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("fatal_post_reset", a_outs(), 0);
    tick();
    @(negedge clk);
    chk("fatal_cleared {state,fatal,ir,err}", {a_state, a_fatal, a_in_ready, a_err_count}, {2'd0, 1'b0, 1'b1, 16'd0});
    tick();

    // Saturation on B: five isolated errors, each with a good replay.
    for (int i = 0; i < 5; i++) begin
      b_in_valid = 1'b1; b_up_data = 8'h01; b_up_par = 1'b0;
      @(negedge clk);
      chk("b_bad_accept", b_in_ready, 1);
      tick();
      b_in_valid = 1'b0;
      @(negedge clk);
      chk("b_perr", b_parity_err, 1);
      tick();
      @(negedge clk);
      chk("b_flush_state", b_state, 1);
      tick();
      b_in_valid = 1'b1; b_up_data = 8'h01; b_up_par = 1'b1;
      qb.push_back({1'b1, 8'h01});
      @(negedge clk);
      chk("b_replay {rreq,state,ir}", {b_retry_req, b_state, b_in_ready}, 4'b1101);
      tick();
      b_in_valid = 1'b0;
      tick();
      @(negedge clk);
      chk("b_err_sat", b_err_count, (i >= 2) ? 3 : i + 1);
      chk("b_not_fatal", b_fatal, 0);
      tick();
    end
    chk("final_a_queue_empty", qa.size(), 0);
    chk("final_b_queue_empty", qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
